// File: rtl/ofm_packer.sv
// Packs activation bytes little-endian into OUTPUT_WIDTH words and queues them for a valid/ready consumer.
// Optional OFM_PACKER_OVF_EN adds a sticky ovf_flag output for words dropped on a full queue.

// Word queue: one-cycle push-to-head latency, push accepted when full only if a pop frees the slot.
module ofm_packer_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         wr_en;
  logic         rd_en;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en    = pop && !empty;
  assign wr_en    = push && (!full || rd_en);
  assign head_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_dat;
  end
endmodule

// Packer top: word visible the cycle after its push edge; output held while out_ready is low.
module ofm_packer #(
  parameter int DATA_WIDTH   = 8,
  parameter int OUTPUT_WIDTH = 32,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [15:0]             num_outputs,
  input  logic                    ready_write,
  input  logic [DATA_WIDTH-1:0]   ofm_input,
  output logic [OUTPUT_WIDTH-1:0] MITO_output,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    ready_finish
`ifdef OFM_PACKER_OVF_EN
  ,
  output logic                    ovf_flag
`endif
);
  localparam int LANES = OUTPUT_WIDTH / DATA_WIDTH;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [15:0]             num_reg;
  logic [15:0]             cnt;
  logic [LW-1:0]           lane;
  logic [OUTPUT_WIDTH-1:0] acc;
  logic [OUTPUT_WIDTH-1:0] word_nxt;
  logic                    accept_start;
  logic                    wr_byte;
  logic                    last_byte;
  logic                    push;
  logic                    pop;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic [OUTPUT_WIDTH-1:0] head;

  assign out_valid    = !fifo_empty;
  assign pop          = out_valid && out_ready;
  assign MITO_output  = out_valid ? head : '0;
  assign ready_finish = (state == DONE);
  assign last_byte    = ((cnt + 16'd1) == num_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    accept_start = 1'b0;
    wr_byte      = 1'b0;
    push         = 1'b0;
    word_nxt     = acc;
    for (int k = 0; k < LANES; k++) begin
      if (lane == LW'(k)) word_nxt[k*DATA_WIDTH +: DATA_WIDTH] = ofm_input;
    end
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept_start = 1'b1;
          state_nxt    = (num_outputs != 16'd0) ? COLLECT : DONE;
        end
      end
      COLLECT: begin
        if (ready_write) begin
          wr_byte = 1'b1;
          push    = last_byte || (lane == LW'(LANES - 1));
          if (last_byte) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator is cleared after every push so a short final word has zero upper lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_reg <= '0;
      cnt     <= '0;
      lane    <= '0;
      acc     <= '0;
    end else if (accept_start) begin
      num_reg <= num_outputs;
      cnt     <= '0;
      lane    <= '0;
      acc     <= '0;
    end else if (wr_byte) begin
      cnt <= cnt + 16'd1;
      if (push) begin
        lane <= '0;
        acc  <= '0;
      end else begin
        lane <= lane + LW'(1);
        acc  <= word_nxt;
      end
    end
  end

  ofm_packer_fifo #(
    .W     (OUTPUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (word_nxt),
    .pop      (pop),
    .head_dat (head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

`ifdef OFM_PACKER_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              ovf_flag <= 1'b0;
    else if (accept_start)                   ovf_flag <= 1'b0;
    else if (push && fifo_full && !pop)      ovf_flag <= 1'b1;
  end
`else
  logic unused_full;
  assign unused_full = fifo_full;
`endif
endmodule

// File: tb/tb_ofm_packer.sv
// Directed bench for ofm_packer: packing, partial words, overflow, full push+pop, reset and empty layers.
module tb_ofm_packer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] num_outputs;
  logic        ready_write;
  logic [7:0]  ofm_input;
  logic [31:0] MITO_output;
  logic        out_valid;
  logic        out_ready;
  logic        ready_finish;
`ifdef OFM_PACKER_OVF_EN
  logic        ovf_flag;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] got[$];

  always #5 clk = ~clk;

  ofm_packer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_outputs  (num_outputs),
    .ready_write  (ready_write),
    .ofm_input    (ofm_input),
    .MITO_output  (MITO_output),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .ready_finish (ready_finish)
`ifdef OFM_PACKER_OVF_EN
    ,
    .ovf_flag     (ovf_flag)
`endif
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Records the transfer that the coming edge performs, then advances one cycle.
  task automatic tick();
    if (out_valid && out_ready) got.push_back(MITO_output);
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    ready_write = 1'b1;
    ofm_input   = b;
    tick();
    ready_write = 1'b0;
  endtask

  task automatic begin_layer(input logic [15:0] n);
    start       = 1'b1;
    num_outputs = n;
    tick();
    start       = 1'b0;
  endtask

  task automatic wait_finish(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (ready_finish) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  function automatic logic [31:0] seq_word(input int j);
    return {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; num_outputs = '0; ready_write = 1'b0;
    ofm_input = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++; if (MITO_output !== 32'h0) begin miscompares++; $display("FAIL reset_mito got %h want 0", MITO_output); end
    vectors++; if (ready_finish !== 1'b0) begin miscompares++; $display("FAIL reset_ready_finish got %b want 0", ready_finish); end
    rst_n = 1'b1;
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL idle_out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_zero_layer();
    bit seen_valid;
    got.delete();
    out_ready = 1'b1;
    begin_layer(16'd0);
    vectors++; if (ready_finish !== 1'b1) begin miscompares++; $display("FAIL zero_ready_finish got %b want 1", ready_finish); end
    seen_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b0) seen_valid = 1'b1;
      tick();
    end
    vectors++; if (seen_valid !== 1'b0 || got.size() != 0) begin
      miscompares++; $display("FAIL zero_no_output got valid_seen=%b words=%0d want 0/0", seen_valid, got.size());
    end
  endtask

  task automatic test_pack8();
    logic [31:0] exp [2];
    logic [31:0] g;
    bit ok;
    exp[0] = 32'h04030201; exp[1] = 32'h08070605;
    got.delete();
    out_ready = 1'b1;
    begin_layer(16'd8);
    vectors++; if (ready_finish !== 1'b0) begin miscompares++; $display("FAIL pack8_finish_clear got %b want 0", ready_finish); end
    for (int b = 1; b <= 8; b++) begin
      send_byte(8'(b));
      if (b == 4) begin
        vectors++; if (out_valid !== 1'b1 || MITO_output !== 32'h04030201) begin
          miscompares++; $display("FAIL pack8_latency got v=%b %h want 1 04030201", out_valid, MITO_output);
        end
      end
    end
    wait_finish(20, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL pack8_finish_timeout got 0 want 1"); end
    vectors++; if (got.size() != 2) begin miscompares++; $display("FAIL pack8_count got %0d want 2", got.size()); end
    for (int i = 0; i < 2; i++) begin
      g = (i < got.size()) ? got[i] : 32'hxxxxxxxx;
      vectors++; if (g !== exp[i]) begin miscompares++; $display("FAIL pack8_word%0d got %h want %h", i, g, exp[i]); end
    end
    repeat (3) tick();
    vectors++; if (ready_finish !== 1'b1) begin miscompares++; $display("FAIL pack8_finish_hold got %b want 1", ready_finish); end
  endtask

  task automatic test_pack5();
    logic [31:0] exp [2];
    logic [31:0] g;
    bit ok;
    exp[0] = 32'hDDCCBBAA; exp[1] = 32'h000000EE;
    got.delete();
    out_ready = 1'b1;
    begin_layer(16'd5);
    vectors++; if (ready_finish !== 1'b0) begin miscompares++; $display("FAIL pack5_finish_clear got %b want 0", ready_finish); end
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    start = 1'b1; num_outputs = 16'd2;
    send_byte(8'hDD);
    start = 1'b0;
    send_byte(8'hEE);
    wait_finish(20, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL pack5_finish_timeout got 0 want 1"); end
    vectors++; if (got.size() != 2) begin miscompares++; $display("FAIL pack5_count got %0d want 2", got.size()); end
    for (int i = 0; i < 2; i++) begin
      g = (i < got.size()) ? got[i] : 32'hxxxxxxxx;
      vectors++; if (g !== exp[i]) begin miscompares++; $display("FAIL pack5_word%0d got %h want %h", i, g, exp[i]); end
    end
    vectors++; if (out_valid !== 1'b0 || MITO_output !== 32'h0) begin
      miscompares++; $display("FAIL pack5_idle_out got v=%b %h want 0 0", out_valid, MITO_output);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] g;
    bit ok;
    got.delete();
    out_ready = 1'b0;
    begin_layer(16'd80);
    for (int i = 0; i < 80; i++) send_byte(8'(i));
    repeat (3) tick();
    vectors++; if (out_valid !== 1'b1 || MITO_output !== 32'h03020100) begin
      miscompares++; $display("FAIL ovf_hold got v=%b %h want 1 03020100", out_valid, MITO_output);
    end
    vectors++; if (ready_finish !== 1'b0) begin miscompares++; $display("FAIL ovf_not_done got %b want 0", ready_finish); end
`ifdef OFM_PACKER_OVF_EN
    vectors++; if (ovf_flag !== 1'b1) begin miscompares++; $display("FAIL ovf_flag_set got %b want 1", ovf_flag); end
`endif
    out_ready = 1'b1;
    wait_finish(60, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL ovf_finish_timeout got 0 want 1"); end
    vectors++; if (got.size() != 16) begin miscompares++; $display("FAIL ovf_count got %0d want 16", got.size()); end
    for (int j = 0; j < 16; j++) begin
      g = (j < got.size()) ? got[j] : 32'hxxxxxxxx;
      vectors++; if (g !== seq_word(j)) begin miscompares++; $display("FAIL ovf_word%0d got %h want %h", j, g, seq_word(j)); end
    end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] g;
    bit ok;
    got.delete();
    out_ready = 1'b0;
    begin_layer(16'd68);
`ifdef OFM_PACKER_OVF_EN
    vectors++; if (ovf_flag !== 1'b0) begin miscompares++; $display("FAIL fpp_ovf_cleared got %b want 0", ovf_flag); end
`endif
    for (int i = 0; i < 67; i++) send_byte(8'(i));
    out_ready = 1'b1;
    send_byte(8'd67);
`ifdef OFM_PACKER_OVF_EN
    vectors++; if (ovf_flag !== 1'b0) begin miscompares++; $display("FAIL fpp_ovf_flag got %b want 0", ovf_flag); end
`endif
    wait_finish(60, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL fpp_finish_timeout got 0 want 1"); end
    vectors++; if (got.size() != 17) begin miscompares++; $display("FAIL fpp_count got %0d want 17", got.size()); end
    for (int j = 0; j < 17; j++) begin
      g = (j < got.size()) ? got[j] : 32'hxxxxxxxx;
      vectors++; if (g !== seq_word(j)) begin miscompares++; $display("FAIL fpp_word%0d got %h want %h", j, g, seq_word(j)); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] g;
    bit ok;
    got.delete();
    out_ready = 1'b0;
    begin_layer(16'd8);
    for (int i = 0; i < 7; i++) send_byte(8'(8'h10 + i));
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rst_pre_valid got %b want 1", out_valid); end
    rst_n = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0 || MITO_output !== 32'h0 || ready_finish !== 1'b0) begin
      miscompares++; $display("FAIL rst_async got v=%b %h f=%b want 0 0 0", out_valid, MITO_output, ready_finish);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) send_byte(8'h55);
    repeat (2) tick();
    vectors++; if (got.size() != 0 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL rst_no_output got words=%0d v=%b want 0 0", got.size(), out_valid);
    end
    begin_layer(16'd4);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    wait_finish(20, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL rst_new_finish_timeout got 0 want 1"); end
    g = (got.size() == 1) ? got[0] : 32'hxxxxxxxx;
    vectors++; if (g !== 32'h44332211) begin
      miscompares++; $display("FAIL rst_new_word got %h (n=%0d) want 44332211", g, got.size());
    end
  endtask

  initial begin
    test_reset();
    test_zero_layer();
    test_pack8();
    test_pack5();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
